// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan controller: converts a binary value to BCD one
// shift per clock (shift-and-add-3) and time-shares one BCD decoder across NDIG digits.
module display_scan_ctrl #(
    parameter int NDIG     = 4,
    parameter int WIDTH    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             blank_lz,
    output logic             busy,
    output logic             overflow,
    output logic [3:0]       bcd_out,
    output logic [NDIG-1:0]  digit_en
);

    localparam int SW = NDIG * 4 + 4;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] MAX_SHOWN = WIDTH'(10 ** NDIG - 1);

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       bin_q, bin_d;
    logic [SW-1:0]          bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]          iter_q, iter_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic                   ovf_q, ovf_d;
    logic [NDIG-1:0][3:0]   disp_q, disp_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NDIG:0]          zero_above;
    logic                   lead_blank;

    // Add-3 correction on every scratch nibble before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < SW / 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    bin_d      = value;
                    bcd_d      = '0;
                    iter_d     = CW'(WIDTH);
                    ovf_pend_d = (value > MAX_SHOWN);
                    state_d    = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d  = (bcd_adj << 1) | SW'(bin_q[WIDTH-1]);
                bin_d  = bin_q << 1;
                iter_d = iter_q - 1'b1;
                // Final shift: publish digits and overflow together so the
                // display never shows a mix of old and new state.
                if (iter_q == CW'(1)) begin
                    disp_d  = bcd_d[NDIG*4-1:0];
                    ovf_d   = ovf_pend_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
            presc_q    <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
        end
    end

    // zero_above[i] is high when digits i..NDIG-1 are all zero.
    assign zero_above[NDIG] = 1'b1;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_zero
            assign zero_above[gi] = zero_above[gi+1] && (disp_q[gi] == 4'd0);
        end
    endgenerate

    assign lead_blank = blank_lz && (idx_q != '0) && zero_above[idx_q];
    assign bcd_out    = disp_q[idx_q];
    assign digit_en   = (ovf_q || lead_blank) ? '1 : ~(NDIG'(1) << idx_q);
    assign busy       = (state_q == S_CONV);
    assign overflow   = ovf_q;

endmodule
